// File: rtl/paws_reset_pkg.sv
// Shared types and default timing for the board reset sequencer.
// Cycle defaults assume the free-running 25 MHz board clock.
package paws_reset_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        SDRAM_UP,
        SYS_UP,
        IO_UP,
        RUN
    } seqState_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_SDRAM_INIT_CYCLES  = 5000;
    localparam int DEF_STAGE_GAP_CYCLES   = 16;
    localparam int DEF_SWRST_HOLD_CYCLES  = 64;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/paws_sync_bit.sv
// N-flop single-bit synchroniser, cleared asynchronously.
// Used for the PLL lock flag and for the local reset release.
module paws_sync_bit #(
    parameter int N = 2
) (
    input  logic clock,
    input  logic resetN,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/paws_reset_sequencer.sv
// Ordered active-low reset release for SDRAM, system and I/O domains,
// gated on a stable PLL lock and restarted on lock loss or software request.
module paws_reset_sequencer
    import paws_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int SDRAM_INIT_CYCLES  = DEF_SDRAM_INIT_CYCLES,
    parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
    parameter int SWRST_HOLD_CYCLES  = DEF_SWRST_HOLD_CYCLES
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       lock_in,
    input  logic       sw_reset_req,
    output logic       rst_sdram_n,
    output logic       rst_system_n,
    output logic       rst_io_n,
    output logic       ready,
    output logic [7:0] lock_lost_cnt
);

    localparam int MAX_CYC = maxOf(
        maxOf(LOCK_STABLE_CYCLES, SDRAM_INIT_CYCLES),
        maxOf(STAGE_GAP_CYCLES, SWRST_HOLD_CYCLES));
    localparam int CW = $clog2(MAX_CYC) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t HOLD_LAST  = cnt_t'(SWRST_HOLD_CYCLES - 1);
    localparam cnt_t LOCK_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t SDRAM_LAST = cnt_t'(SDRAM_INIT_CYCLES - 1);
    localparam cnt_t GAP_LAST   = cnt_t'(STAGE_GAP_CYCLES - 1);

    logic      lockS;
    logic      rstRelease;
    seqState_t state;
    seqState_t nextState;
    cnt_t      cnt;
    cnt_t      nextCnt;
    logic      lostInc;
    logic      sdramOn;
    logic      sysOn;
    logic      ioOn;

    paws_sync_bit #(.N(SYNC_STAGES)) uLockSync (
        .clock  (clock),
        .resetN (reset_n),
        .d      (lock_in),
        .q      (lockS)
    );

    paws_sync_bit #(.N(2)) uRstSync (
        .clock  (clock),
        .resetN (reset_n),
        .d      (1'b1),
        .q      (rstRelease)
    );

    always_comb begin
        nextState = state;
        nextCnt   = cnt + 1'b1;
        if (!rstRelease || sw_reset_req) begin
            nextState = HOLD;
            nextCnt   = '0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) nextState = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (!lockS) nextCnt = '0;
                    else if (cnt == LOCK_LAST) nextState = SDRAM_UP;
                end
                SDRAM_UP: begin
                    if (!lockS) nextState = HOLD;
                    else if (cnt == SDRAM_LAST) nextState = SYS_UP;
                end
                SYS_UP: begin
                    if (!lockS) nextState = HOLD;
                    else if (cnt == GAP_LAST) nextState = IO_UP;
                end
                IO_UP: begin
                    if (!lockS) nextState = HOLD;
                    else if (cnt == GAP_LAST) nextState = RUN;
                end
                RUN: begin
                    nextCnt = cnt;
                    if (!lockS) nextState = HOLD;
                end
                default: nextState = HOLD;
            endcase
            // Every state entry restarts the shared counter.
            if (nextState != state) nextCnt = '0;
        end
    end

    assign lostInc = rstRelease && !sw_reset_req &&
                     (state == RUN) && !lockS;

    // Outputs decode the next state so they are registered and glitch-free.
    assign sdramOn = nextState inside {SDRAM_UP, SYS_UP, IO_UP, RUN};
    assign sysOn   = nextState inside {SYS_UP, IO_UP, RUN};
    assign ioOn    = nextState inside {IO_UP, RUN};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= HOLD;
            cnt           <= '0;
            rst_sdram_n   <= 1'b0;
            rst_system_n  <= 1'b0;
            rst_io_n      <= 1'b0;
            ready         <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            state        <= nextState;
            cnt          <= nextCnt;
            rst_sdram_n  <= sdramOn;
            rst_system_n <= sysOn;
            rst_io_n     <= ioOn;
            ready        <= (nextState == RUN);
            if (lostInc && (lock_lost_cnt != 8'hFF)) begin
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_paws_reset_sequencer.sv
// Scoreboard bench for paws_reset_sequencer with small timing parameters.
// Expected output changes are queued with their cycle; a monitor pops them.
module tb_paws_reset_sequencer;

    localparam int SYNC    = 2;
    localparam int LOCK    = 8;
    localparam int SDRAM   = 20;
    localparam int GAP     = 4;
    localparam int HOLDC   = 4;
    localparam int LATENCY = SYNC + HOLDC + LOCK + SDRAM + 2 * GAP;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock_in = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       rst_sdram_n;
    logic       rst_system_n;
    logic       rst_io_n;
    logic       ready;
    logic [7:0] lock_lost_cnt;

    typedef struct {
        int          cyc;
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          expCnt = 0;
    int          base;
    int          b2;
    bit          armed = 1'b0;
    logic [11:0] prev = '0;
    logic [11:0] monCur;
    logic [11:0] outVec;

    paws_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LOCK),
        .SDRAM_INIT_CYCLES  (SDRAM),
        .STAGE_GAP_CYCLES   (GAP),
        .SWRST_HOLD_CYCLES  (HOLDC)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .lock_in       (lock_in),
        .sw_reset_req  (sw_reset_req),
        .rst_sdram_n   (rst_sdram_n),
        .rst_system_n  (rst_system_n),
        .rst_io_n      (rst_io_n),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    assign outVec = {rst_sdram_n, rst_system_n, rst_io_n, ready, lock_lost_cnt};

    function automatic logic [11:0] vec(bit s, bit y, bit i, bit r, int c);
        return {s, y, i, r, 8'(c)};
    endfunction

    task automatic pushExp(int c, logic [11:0] v, string n);
        expQ.push_back('{c, v, n});
    endtask

    task automatic ramp(int b, int c);
        pushExp(b, vec(1, 0, 0, 0, c), "sdram release");
        pushExp(b + SDRAM, vec(1, 1, 0, 0, c), "system release");
        pushExp(b + SDRAM + GAP, vec(1, 1, 1, 0, c), "io release");
        pushExp(b + SDRAM + 2 * GAP, vec(1, 1, 1, 1, c), "ready");
    endtask

    task automatic tickTo(int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic checkNow(string n, logic [11:0] act, logic [11:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", n, act, req);
        end
    endtask

    task automatic drain(string n);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d events pending, required 0 (next '%s' due cycle %0d)",
                     n, expQ.size(), expQ[0].name, expQ[0].cyc);
            expQ.delete();
        end
    endtask

    // Lock drop from RUN, then re-raise once the loss has been seen.
    task automatic lockLoss();
        if (expCnt < 255) expCnt++;
        @(negedge clock);
        lock_in = 1'b0;
        base = cyc;
        pushExp(base + SYNC + 1, vec(0, 0, 0, 0, expCnt), "lock loss");
        tickTo(base + SYNC + 1);
        lock_in = 1'b1;
        b2 = cyc;
        ramp(b2 + HOLDC + SYNC + LOCK - 2, expCnt);
        tickTo(b2 + HOLDC + SYNC + LOCK - 2 + SDRAM + 2 * GAP + 2);
    endtask

    always @(negedge clock) begin
        if (armed) begin
            monCur = outVec;
            if (monCur !== prev) begin
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected change: got %h at cycle %0d, required no change",
                             monCur, cyc);
                end else begin
                    monExp = expQ.pop_front();
                    if (monExp.cyc != cyc || monExp.v !== monCur) begin
                        fails++;
                        $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                                 monExp.name, monCur, cyc, monExp.v, monExp.cyc);
                    end
                end
                prev = monCur;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        lock_in = 1'b1;
        sw_reset_req = 1'b0;
        repeat (3) @(negedge clock);
        checkNow("reset state", outVec, vec(0, 0, 0, 0, 0));
        armed = 1'b1;

        // Power-up with lock steady: release edges counted from reset_n rise.
        reset_n = 1'b1;
        base = cyc;
        ramp(base + SYNC + HOLDC + LOCK, 0);
        tickTo(base + LATENCY + 3);
        drain("power-up sequence");

        // Lock loss in RUN, then recovery.
        lockLoss();
        drain("lock loss recovery");

        // Software reset in RUN: counter untouched, hold then full re-run.
        sw_reset_req = 1'b1;
        base = cyc;
        pushExp(base + 1, vec(0, 0, 0, 0, expCnt), "sw reset");
        ramp(base + 1 + HOLDC + LOCK, expCnt);
        @(negedge clock);
        sw_reset_req = 1'b0;
        tickTo(base + 1 + HOLDC + LOCK + SDRAM + 2 * GAP + 2);
        drain("sw reset sequence");

        // Software reset coinciding with lock loss: no count.
        lock_in = 1'b0;
        base = cyc;
        pushExp(base + SYNC + 1, vec(0, 0, 0, 0, expCnt), "sw plus lock loss");
        tickTo(base + SYNC);
        sw_reset_req = 1'b1;
        tickTo(base + SYNC + 1);
        sw_reset_req = 1'b0;
        lock_in = 1'b1;
        b2 = cyc;
        ramp(b2 + HOLDC + SYNC + LOCK - 2, expCnt);
        tickTo(b2 + HOLDC + SYNC + LOCK - 2 + SDRAM + 2 * GAP + 2);
        drain("sw plus lock loss sequence");

        // Saturation of the lock-loss counter.
        for (int i = 0; i < 300; i++) lockLoss();
        drain("saturation sequence");
        checkNow("lock_lost_cnt saturated", outVec, vec(1, 1, 1, 1, 255));

        // Async reset during SDRAM_UP.
        @(negedge clock);
        sw_reset_req = 1'b1;
        base = cyc;
        pushExp(base + 1, vec(0, 0, 0, 0, expCnt), "sw reset before async");
        pushExp(base + 1 + HOLDC + LOCK, vec(1, 0, 0, 0, expCnt), "sdram before async");
        @(negedge clock);
        sw_reset_req = 1'b0;
        tickTo(base + 1 + HOLDC + LOCK + 3);
        @(posedge clock);
        #2;
        pushExp(cyc, vec(0, 0, 0, 0, 0), "async reset");
        reset_n = 1'b0;
        lock_in = 1'b0;
        #1;
        checkNow("async reset immediate", outVec, vec(0, 0, 0, 0, 0));
        repeat (3) @(negedge clock);
        drain("async reset");
        expCnt = 0;

        // Lock absent after reset: everything stays asserted.
        reset_n = 1'b1;
        base = cyc;
        tickTo(base + 20);
        drain("no lock hold");

        // One-cycle lock glitch after six stable cycles restarts the count.
        lock_in = 1'b1;
        base = cyc;
        ramp(base + SYNC + 7 + LOCK, 0);
        tickTo(base + 6);
        lock_in = 1'b0;
        tickTo(base + 7);
        lock_in = 1'b1;
        tickTo(base + SYNC + 7 + LOCK + SDRAM + 2 * GAP + 3);
        drain("lock glitch sequence");

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
